// File: rtl/ctx_switch_unit_pkg.sv
// Shared definitions for the context save/restore sequencer and the register
// file it works alongside: datapath widths, special-register indices and the
// sequencer state encoding.
package ctx_switch_unit_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_SEL_W = 6;
    localparam int NUM_REGS  = 64;

    // Special-purpose register indices shared with the register file
    localparam int SP  = 51;
    localparam int GP  = 52;
    localparam int JMP = 53;
    localparam int RA  = 54;
    localparam int RET = 55;
    localparam int BR  = 56;
    localparam int CTX = 57;
    localparam int AX1 = 61;
    localparam int AX2 = 62;
    localparam int CRT = 63;

    // Sequencer states, kept as plain constants for older tool flows
    typedef logic [2:0] ctx_state_t;

    localparam ctx_state_t IDLE    = 3'd0;
    localparam ctx_state_t S_ADDR  = 3'd1;
    localparam ctx_state_t S_WRITE = 3'd2;
    localparam ctx_state_t R_READ  = 3'd3;
    localparam ctx_state_t R_WRITE = 3'd4;
    localparam ctx_state_t DONE    = 3'd5;

endpackage

// File: rtl/ctx_switch_unit.sv
// Context save/restore sequencer. Streams registers FIRST_REG..LAST_REG from
// the register file into data memory (save) or back again (restore), starting
// at a latched base word address. All outputs decode from the state register,
// so an asynchronous reset silences them immediately.
module ctx_switch_unit
    import ctx_switch_unit_pkg::*;
#(
    parameter int FIRST_REG  = 1,
    parameter int LAST_REG   = 50,
    parameter int WRITE_HOLD = 4
) (
    input  logic                 Fast_Clock,
    input  logic                 Reset_N,
    input  logic                 Start_Save,
    input  logic                 Start_Restore,
    input  logic [DATA_W-1:0]    Base_Addr,
    output logic                 Busy,
    output logic                 Done,
    output logic [REG_SEL_W-1:0] Ctx_Reg,
    input  logic [DATA_W-1:0]    Reg_Data,
    output logic                 Ctx_Reg_Write,
    output logic [DATA_W-1:0]    Ctx_Write_Data,
    output logic [DATA_W-1:0]    Mem_Addr,
    output logic                 Mem_Write,
    output logic                 Mem_Read,
    output logic [DATA_W-1:0]    Mem_Wdata,
    input  logic [DATA_W-1:0]    Mem_Rdata,
    input  logic                 Mem_Ready
);

    localparam int HOLD_W = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

    localparam logic [REG_SEL_W-1:0] FIRST_SEL = REG_SEL_W'(FIRST_REG);
    localparam logic [REG_SEL_W-1:0] LAST_SEL  = REG_SEL_W'(LAST_REG);
    localparam logic [HOLD_W-1:0]    HOLD_INIT = HOLD_W'(WRITE_HOLD - 1);

    ctx_state_t           state;
    logic [REG_SEL_W-1:0] idx;
    logic [DATA_W-1:0]    base;
    logic [DATA_W-1:0]    data;
    logic [HOLD_W-1:0]    hold;
    logic [DATA_W-1:0]    addr;
    logic                 last_reg;

    // idx never drops below FIRST_SEL while active, so the offset cannot underflow
    assign addr     = base + DATA_W'(idx - FIRST_SEL);
    assign last_reg = (idx == LAST_SEL);

    // Sequencer FSM with the index, base, data and write-hold registers
    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state <= IDLE;
            idx   <= '0;
            base  <= '0;
            data  <= '0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start_Save) begin
                        state <= S_ADDR;
                        idx   <= FIRST_SEL;
                        base  <= Base_Addr;
                    end else if (Start_Restore) begin
                        state <= R_READ;
                        idx   <= FIRST_SEL;
                        base  <= Base_Addr;
                    end
                end
                S_ADDR: begin
                    data  <= Reg_Data;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (Mem_Ready) begin
                        if (last_reg) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_ADDR;
                        end
                    end
                end
                R_READ: begin
                    if (Mem_Ready) begin
                        data  <= Mem_Rdata;
                        hold  <= HOLD_INIT;
                        state <= R_WRITE;
                    end
                end
                R_WRITE: begin
                    if (hold == '0) begin
                        if (last_reg) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= R_READ;
                        end
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode: each output is driven only in the state that owns it
    always_comb begin
        Busy           = (state != IDLE);
        Done           = (state == DONE);
        Ctx_Reg        = '0;
        Ctx_Reg_Write  = 1'b0;
        Ctx_Write_Data = '0;
        Mem_Addr       = '0;
        Mem_Write      = 1'b0;
        Mem_Read       = 1'b0;
        Mem_Wdata      = '0;
        case (state)
            S_ADDR: begin
                Ctx_Reg = idx;
            end
            S_WRITE: begin
                Mem_Write = 1'b1;
                Mem_Addr  = addr;
                Mem_Wdata = data;
            end
            R_READ: begin
                Mem_Read = 1'b1;
                Mem_Addr = addr;
            end
            R_WRITE: begin
                Ctx_Reg        = idx;
                Ctx_Reg_Write  = 1'b1;
                Ctx_Write_Data = data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ctx_switch_unit.sv
// Testbench for ctx_switch_unit: models the register file and a word memory
// with programmable Mem_Ready stalls, and checks each scenario against
// expectations computed from the save/restore rules.
module tb_ctx_switch_unit;

    localparam int FIRST = 1;
    localparam int LAST  = 50;
    localparam int HOLD  = 4;
    localparam int N     = LAST - FIRST + 1;

    logic        Fast_Clock = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Start_Save = 1'b0;
    logic        Start_Restore = 1'b0;
    logic [31:0] Base_Addr = '0;
    logic        Busy, Done, Ctx_Reg_Write, Mem_Write, Mem_Read;
    logic [5:0]  Ctx_Reg;
    logic [31:0] Reg_Data, Ctx_Write_Data, Mem_Addr, Mem_Wdata;
    logic [31:0] Mem_Rdata = '0;
    logic        Mem_Ready = 1'b1;

    logic [31:0] rf [64];
    logic [31:0] mem [4096];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int start_cyc, done_cyc, done_count = 0, done_base;
    int stall_mode = 0, stall_left = 0, stalls_injected = 0, req_num = 0;
    int stab_err, overlap_err, zero_sel_err, idle_err, we_reg_err, read_count;
    int we_run = 0;
    int we_widths [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    bit          req_pending = 0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_w, prev_r;
    logic [5:0]  we_reg;

    ctx_switch_unit #(.FIRST_REG(FIRST), .LAST_REG(LAST), .WRITE_HOLD(HOLD)) dut (
        .Fast_Clock(Fast_Clock), .Reset_N(Reset_N),
        .Start_Save(Start_Save), .Start_Restore(Start_Restore), .Base_Addr(Base_Addr),
        .Busy(Busy), .Done(Done), .Ctx_Reg(Ctx_Reg), .Reg_Data(Reg_Data),
        .Ctx_Reg_Write(Ctx_Reg_Write), .Ctx_Write_Data(Ctx_Write_Data),
        .Mem_Addr(Mem_Addr), .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
        .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Ready(Mem_Ready)
    );

    assign Reg_Data = rf[Ctx_Reg];

    always #5 Fast_Clock = ~Fast_Clock;

    // Cycle counter: value equals the number of rising edges seen so far
    always @(posedge Fast_Clock) cyc <= cyc + 1;

    // Register file, memory and protocol monitor, all evaluated mid-cycle
    always @(negedge Fast_Clock) begin
        logic [31:0] a;
        if (!Reset_N) begin
            req_pending = 0;
            stall_left  = 0;
            we_run      = 0;
            Mem_Ready   = 1'b1;
        end else begin
            if (Done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (Ctx_Reg_Write && (Mem_Write || Mem_Read)) overlap_err++;
            if (Ctx_Reg_Write && Ctx_Reg == 6'd0) zero_sel_err++;
            if (!Busy && (Ctx_Reg != 0 || Ctx_Reg_Write || Mem_Write || Mem_Read ||
                          Mem_Addr != 0 || Mem_Wdata != 0 || Ctx_Write_Data != 0 || Done))
                idle_err++;
            if (Ctx_Reg_Write) begin
                if (we_run == 0) we_reg = Ctx_Reg;
                else if (Ctx_Reg != we_reg) we_reg_err++;
                we_run++;
                rf[Ctx_Reg] = Ctx_Write_Data;
            end else if (we_run != 0) begin
                we_widths.push_back(we_run);
                we_run = 0;
            end
            if (Mem_Write || Mem_Read) begin
                if (!req_pending) begin
                    req_pending = 1;
                    req_num++;
                    prev_addr  = Mem_Addr;
                    prev_wdata = Mem_Wdata;
                    prev_w     = Mem_Write;
                    prev_r     = Mem_Read;
                    case (stall_mode)
                        1:       stall_left = (req_num % 3 == 0) ? 3 : 0;
                        2:       stall_left = $urandom_range(0, 2);
                        default: stall_left = 0;
                    endcase
                end else if (Mem_Addr !== prev_addr || Mem_Wdata !== prev_wdata ||
                             Mem_Write !== prev_w || Mem_Read !== prev_r) begin
                    stab_err++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    stalls_injected++;
                    Mem_Ready = 1'b0;
                    Mem_Rdata = 32'hDEAD_BEEF;
                end else begin
                    Mem_Ready   = 1'b1;
                    req_pending = 0;
                    a = Mem_Addr;
                    if (Mem_Write) begin
                        mem[a[11:0]] = Mem_Wdata;
                        wr_addr_q.push_back(Mem_Addr);
                        wr_data_q.push_back(Mem_Wdata);
                    end else begin
                        Mem_Rdata = mem[a[11:0]];
                        read_count++;
                    end
                end
            end else begin
                Mem_Ready = 1'b1;
            end
        end
    end

    task automatic clear_stats(input int mode);
        stall_mode = mode;
        stalls_injected = 0; req_num = 0;
        stab_err = 0; overlap_err = 0; zero_sel_err = 0; idle_err = 0;
        we_reg_err = 0; read_count = 0;
        we_widths.delete(); wr_addr_q.delete(); wr_data_q.delete();
        done_base = done_count;
    endtask

    task automatic start_seq(input bit save, input bit restore, input logic [31:0] base);
        @(negedge Fast_Clock);
        Start_Save = save; Start_Restore = restore; Base_Addr = base;
        @(posedge Fast_Clock); #1;
        start_cyc = cyc;
        Start_Save = 1'b0; Start_Restore = 1'b0; Base_Addr = $urandom;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Fast_Clock); #1;
            if (done_count != done_base) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (Busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", Busy); else passes++;
        checks++; if (Done !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", Done); else passes++;
        checks++; if (Ctx_Reg !== 6'd0) $display("[TB] FAIL reset_ctx_reg: got %0d expected 0", Ctx_Reg); else passes++;
        checks++; if (Ctx_Reg_Write !== 1'b0) $display("[TB] FAIL reset_reg_write: got %0b expected 0", Ctx_Reg_Write); else passes++;
        checks++; if (Ctx_Write_Data !== 32'd0) $display("[TB] FAIL reset_write_data: got %0h expected 0", Ctx_Write_Data); else passes++;
        checks++; if (Mem_Addr !== 32'd0) $display("[TB] FAIL reset_mem_addr: got %0h expected 0", Mem_Addr); else passes++;
        checks++; if (Mem_Write !== 1'b0) $display("[TB] FAIL reset_mem_write: got %0b expected 0", Mem_Write); else passes++;
        checks++; if (Mem_Read !== 1'b0) $display("[TB] FAIL reset_mem_read: got %0b expected 0", Mem_Read); else passes++;
        checks++; if (Mem_Wdata !== 32'd0) $display("[TB] FAIL reset_mem_wdata: got %0h expected 0", Mem_Wdata); else passes++;
        @(negedge Fast_Clock); Reset_N = 1'b1;
        repeat (2) @(negedge Fast_Clock); #1;
        checks++; if (Busy !== 1'b0) $display("[TB] FAIL idle_busy: got %0b expected 0", Busy); else passes++;
    endtask

    task automatic test_save();
        bit to;
        logic [31:0] a;
        for (int k = 0; k < 64; k++) rf[k] = 32'(3 * k);
        rf[0] = 32'hBAD0_0000;
        clear_stats(0);
        start_seq(1, 0, 32'h100);
        checks++; if (Busy !== 1'b1) $display("[TB] FAIL save_busy_rise: got %0b expected 1", Busy); else passes++;
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL save_timeout: got timeout expected Done"); else passes++;
        checks++; if (done_cyc - start_cyc != 2 * N) $display("[TB] FAIL save_done_cycle: got t+%0d expected t+%0d", done_cyc - start_cyc + 1, 2 * N + 1); else passes++;
        checks++; if (wr_addr_q.size() != N) $display("[TB] FAIL save_write_count: got %0d expected %0d", wr_addr_q.size(), N); else passes++;
        for (int k = FIRST; k <= LAST; k++) begin
            a = 32'h100 + 32'(k - 1);
            checks++; if (mem[a[11:0]] !== 32'(3 * k)) $display("[TB] FAIL save_mem[%0h]: got %0h expected %0h", a, mem[a[11:0]], 3 * k); else passes++;
        end
        checks++; if (read_count != 0 || idle_err != 0) $display("[TB] FAIL save_protocol: got reads=%0d idle_err=%0d expected 0", read_count, idle_err); else passes++;
        @(negedge Fast_Clock); #1;
        checks++; if (Busy !== 1'b0) $display("[TB] FAIL save_busy_fall: got %0b expected 0", Busy); else passes++;
    endtask

    task automatic test_restore();
        bit to;
        logic [31:0] a;
        logic [31:0] upper [64];
        for (int i = 0; i < N; i++) begin
            a = 32'h200 + 32'(i);
            mem[a[11:0]] = 32'hA000 + 32'(i);
        end
        for (int k = 0; k < 64; k++) begin
            rf[k] = $urandom;
            upper[k] = rf[k];
        end
        clear_stats(0);
        start_seq(0, 1, 32'h200);
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL restore_timeout: got timeout expected Done"); else passes++;
        checks++; if (done_cyc - start_cyc != N * (1 + HOLD)) $display("[TB] FAIL restore_done_cycle: got t+%0d expected t+%0d", done_cyc - start_cyc + 1, N * (1 + HOLD) + 1); else passes++;
        for (int i = 0; i < N; i++) begin
            checks++; if (rf[i + 1] !== 32'hA000 + 32'(i)) $display("[TB] FAIL restore_r%0d: got %0h expected %0h", i + 1, rf[i + 1], 32'hA000 + i); else passes++;
        end
        checks++; if (rf[0] !== upper[0] || rf[LAST + 1] !== upper[LAST + 1] || rf[63] !== upper[63]) $display("[TB] FAIL restore_untouched: got r0=%0h r%0d=%0h expected r0=%0h r%0d=%0h", rf[0], LAST + 1, rf[LAST + 1], upper[0], LAST + 1, upper[LAST + 1]); else passes++;
        checks++; if (we_widths.size() != N) $display("[TB] FAIL restore_we_count: got %0d expected %0d", we_widths.size(), N); else passes++;
        foreach (we_widths[i]) begin
            if (we_widths[i] != HOLD) begin
                checks++; $display("[TB] FAIL restore_we_width[%0d]: got %0d expected %0d", i, we_widths[i], HOLD);
            end
        end
        checks++; if (overlap_err != 0 || zero_sel_err != 0 || we_reg_err != 0) $display("[TB] FAIL restore_protocol: got overlap=%0d zero_sel=%0d reg_change=%0d expected 0", overlap_err, zero_sel_err, we_reg_err); else passes++;
    endtask

    task automatic test_save_stall();
        bit to;
        logic [31:0] a;
        for (int k = 0; k < 64; k++) rf[k] = 32'(3 * k);
        for (int i = 0; i < N; i++) begin
            a = 32'h100 + 32'(i);
            mem[a[11:0]] = 32'h0;
        end
        clear_stats(1);
        start_seq(1, 0, 32'h100);
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL stall_timeout: got timeout expected Done"); else passes++;
        checks++; if (done_cyc - start_cyc != 2 * N + 3 * (N / 3)) $display("[TB] FAIL stall_done_cycle: got t+%0d expected t+%0d", done_cyc - start_cyc + 1, 2 * N + 3 * (N / 3) + 1); else passes++;
        checks++; if (stab_err != 0) $display("[TB] FAIL stall_stability: got %0d changes expected 0", stab_err); else passes++;
        for (int k = FIRST; k <= LAST; k++) begin
            a = 32'h100 + 32'(k - 1);
            checks++; if (mem[a[11:0]] !== 32'(3 * k)) $display("[TB] FAIL stall_mem[%0h]: got %0h expected %0h", a, mem[a[11:0]], 3 * k); else passes++;
        end
    endtask

    task automatic test_both_starts();
        bit to;
        for (int k = 0; k < 64; k++) rf[k] = $urandom;
        clear_stats(0);
        start_seq(1, 1, 32'h300);
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL both_timeout: got timeout expected Done"); else passes++;
        checks++; if (wr_addr_q.size() != N || read_count != 0) $display("[TB] FAIL both_save_wins: got writes=%0d reads=%0d expected writes=%0d reads=0", wr_addr_q.size(), read_count, N); else passes++;
        for (int i = 0; i < wr_data_q.size() && i < N; i++) begin
            checks++; if (wr_data_q[i] !== rf[FIRST + i] || wr_addr_q[i] !== 32'h300 + 32'(i)) $display("[TB] FAIL both_write[%0d]: got %0h@%0h expected %0h@%0h", i, wr_data_q[i], wr_addr_q[i], rf[FIRST + i], 32'h300 + i); else passes++;
        end
    endtask

    task automatic test_ignore_restore();
        bit to;
        for (int k = 0; k < 64; k++) rf[k] = $urandom;
        clear_stats(2);
        start_seq(1, 0, 32'h400);
        repeat (20) @(negedge Fast_Clock);
        Start_Restore = 1'b1;
        @(negedge Fast_Clock);
        Start_Restore = 1'b0;
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL ignore_timeout: got timeout expected Done"); else passes++;
        repeat (20) @(negedge Fast_Clock); #1;
        checks++; if (done_count - done_base != 1) $display("[TB] FAIL ignore_done_count: got %0d expected 1", done_count - done_base); else passes++;
        checks++; if (read_count != 0 || Busy !== 1'b0) $display("[TB] FAIL ignore_no_restore: got reads=%0d busy=%0b expected 0/0", read_count, Busy); else passes++;
        checks++; if (done_cyc - start_cyc != 2 * N + stalls_injected) $display("[TB] FAIL ignore_done_cycle: got t+%0d expected t+%0d", done_cyc - start_cyc + 1, 2 * N + stalls_injected + 1); else passes++;
    endtask

    task automatic test_reset_mid_save();
        bit to;
        bit found = 0;
        logic [31:0] a;
        for (int k = 0; k < 64; k++) rf[k] = $urandom;
        clear_stats(0);
        start_seq(1, 0, 32'h500);
        for (int i = 0; i < 200; i++) begin
            @(negedge Fast_Clock); #1;
            if (Ctx_Reg == 6'd20) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) $display("[TB] FAIL midreset_reach_r20: got no select expected Ctx_Reg=20"); else passes++;
        Reset_N = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Ctx_Reg !== 6'd0 || Mem_Write !== 1'b0 || Mem_Read !== 1'b0 || Mem_Addr !== 32'd0 || Mem_Wdata !== 32'd0 || Ctx_Reg_Write !== 1'b0 || Done !== 1'b0)
            $display("[TB] FAIL midreset_outputs: got busy=%0b reg=%0d mw=%0b mr=%0b addr=%0h expected all 0", Busy, Ctx_Reg, Mem_Write, Mem_Read, Mem_Addr); else passes++;
        checks++; if (wr_addr_q.size() != 19) $display("[TB] FAIL midreset_partial: got %0d writes expected 19", wr_addr_q.size()); else passes++;
        a = 32'h500 + 32'd18;
        checks++; if (mem[a[11:0]] !== rf[19]) $display("[TB] FAIL midreset_kept: got %0h expected %0h", mem[a[11:0]], rf[19]); else passes++;
        repeat (3) @(negedge Fast_Clock);
        Reset_N = 1'b1;
        repeat (5) @(negedge Fast_Clock); #1;
        checks++; if (done_count != done_base) $display("[TB] FAIL midreset_no_done: got %0d expected 0", done_count - done_base); else passes++;
        clear_stats(0);
        start_seq(1, 0, 32'h600);
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL midreset_restart_timeout: got timeout expected Done"); else passes++;
        checks++; if (wr_addr_q.size() != N) $display("[TB] FAIL midreset_restart_count: got %0d expected %0d", wr_addr_q.size(), N); else passes++;
        checks++; if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 32'h600 || wr_data_q[0] !== rf[FIRST]) $display("[TB] FAIL midreset_restart_first: got %0d writes, first addr/data wrong expected %0h@600", wr_addr_q.size(), rf[FIRST]); else passes++;
    endtask

    task automatic test_wrap();
        bit to;
        for (int k = 0; k < 64; k++) rf[k] = $urandom;
        clear_stats(0);
        start_seq(1, 0, 32'hFFFF_FFF0);
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL wrap_timeout: got timeout expected Done"); else passes++;
        checks++; if (wr_addr_q.size() != N) $display("[TB] FAIL wrap_count: got %0d expected %0d", wr_addr_q.size(), N); else passes++;
        for (int i = 0; i < wr_addr_q.size() && i < N; i++) begin
            checks++; if (wr_addr_q[i] !== 32'hFFFF_FFF0 + 32'(i) || wr_data_q[i] !== rf[FIRST + i]) $display("[TB] FAIL wrap_write[%0d]: got %0h@%0h expected %0h@%0h", i, wr_data_q[i], wr_addr_q[i], rf[FIRST + i], 32'hFFFF_FFF0 + 32'(i)); else passes++;
        end
        checks++; if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] !== 32'h21) $display("[TB] FAIL wrap_last: got wrong final address expected 21"); else passes++;
    endtask

    task automatic test_random_roundtrip();
        bit to;
        logic [31:0] orig [64];
        logic [31:0] base;
        base = 32'($urandom_range(32'h800, 32'hF00));
        for (int k = 0; k < 64; k++) begin
            rf[k] = $urandom;
            orig[k] = rf[k];
        end
        clear_stats(2);
        start_seq(1, 0, base);
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL rt_save_timeout: got timeout expected Done"); else passes++;
        checks++; if (stab_err != 0) $display("[TB] FAIL rt_save_stability: got %0d expected 0", stab_err); else passes++;
        for (int k = FIRST; k <= LAST; k++) rf[k] = ~orig[k];
        clear_stats(2);
        start_seq(0, 1, base);
        wait_done(to);
        checks++; if (to) $display("[TB] FAIL rt_restore_timeout: got timeout expected Done"); else passes++;
        checks++; if (done_cyc - start_cyc != N * (1 + HOLD) + stalls_injected) $display("[TB] FAIL rt_done_cycle: got t+%0d expected t+%0d", done_cyc - start_cyc + 1, N * (1 + HOLD) + stalls_injected + 1); else passes++;
        checks++; if (stab_err != 0 || overlap_err != 0) $display("[TB] FAIL rt_restore_protocol: got stab=%0d overlap=%0d expected 0", stab_err, overlap_err); else passes++;
        for (int k = FIRST; k <= LAST; k++) begin
            checks++; if (rf[k] !== orig[k]) $display("[TB] FAIL rt_r%0d: got %0h expected %0h", k, rf[k], orig[k]); else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int k = 0; k < 64; k++) rf[k] = '0;
        test_reset();
        test_save();
        test_restore();
        test_save_stall();
        test_both_starts();
        test_ignore_restore();
        test_reset_mid_save();
        test_wrap();
        test_random_roundtrip();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
